// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter for a shared latch-based register bank.
// Each write is driven as setup -> enable window -> hold so latch D is stable around the enable.
module latch_bank_write_arbiter #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int AW          = 2,
    parameter int OPEN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             ack0,
    input  logic             req1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack1,
    output logic [DEPTH-1:0] lat_en,
    output logic [WIDTH-1:0] lat_d,
    output logic             busy,
    output logic             grant_id
);

    localparam int CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DEPTH-1:0]  lat_en_q, lat_en_d;
    logic [WIDTH-1:0]  lat_d_q, lat_d_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              grant_id_q, grant_id_d;
    logic              win;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        lat_d_d    = lat_d_q;
        grant_id_d = grant_id_q;
        win        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    win        = (req0 && req1) ? ptr_q : req1;
                    grant_id_d = win;
                    ptr_d      = ~win;
                    addr_d     = win ? addr1 : addr0;
                    // lat_d doubles as the captured write data; it only moves on this edge
                    lat_d_d    = win ? wdata1 : wdata0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_OPEN;
            end
            S_OPEN: begin
                if (cnt_q == CW'(OPEN_CYCLES - 1)) state_d = S_HOLD;
                else                               cnt_d   = cnt_q + CW'(1);
            end
            S_HOLD:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        // Out-of-range addresses simply match no enable bit.
        lat_en_d = '0;
        if (state_d == S_OPEN) begin
            for (int i = 0; i < DEPTH; i++) lat_en_d[i] = (addr_d == AW'(i));
        end
        busy_d = (state_d != S_IDLE);
        ack0_d = (state_d == S_DONE) && !grant_id_d;
        ack1_d = (state_d == S_DONE) &&  grant_id_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            addr_q     <= '0;
            lat_en_q   <= '0;
            lat_d_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            grant_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            lat_en_q   <= lat_en_d;
            lat_d_q    <= lat_d_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign lat_en   = lat_en_q;
    assign lat_d    = lat_d_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Bench for latch_bank_write_arbiter: directed scenarios plus random traffic and resets,
// checked every cycle against a transaction-phase reference model.
module tb_latch_bank_write_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int AW    = 2;
    localparam int OC    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1;
    logic [AW-1:0]    addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             ack0, ack1, busy, grant_id;
    logic [DEPTH-1:0] lat_en;
    logic [WIDTH-1:0] lat_d;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: phase = cycles since grant (0 = idle)
    int ph     = 0;
    int m_gid  = 0;
    int m_ptr  = 0;
    int m_addr = 0;
    int m_data = 0;

    latch_bank_write_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .OPEN_CYCLES(OC)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .lat_en(lat_en), .lat_d(lat_d), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_update();
        int w;
        if (reset) begin
            ph = 0; m_gid = 0; m_ptr = 0; m_addr = 0; m_data = 0;
        end else if (ph == 0) begin
            if (req0 || req1) begin
                w      = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
                m_gid  = w;
                m_ptr  = 1 - w;
                m_addr = w ? int'(addr1) : int'(addr0);
                m_data = w ? int'(wdata1) : int'(wdata0);
                ph     = 1;
            end
        end else if (ph == OC + 3) begin
            ph = 0;
        end else begin
            ph++;
        end
    endtask

    task automatic step();
        int exp_en;
        @(posedge clk);
        model_update();
        @(negedge clk);
        exp_en = (ph >= 2 && ph <= OC + 1 && m_addr < DEPTH) ? (1 << m_addr) : 0;
        chk("lat_en",   32'(lat_en),   32'(exp_en));
        chk("lat_d",    32'(lat_d),    32'(m_data));
        chk("ack0",     32'(ack0),     32'(ph == OC + 3 && m_gid == 0));
        chk("ack1",     32'(ack1),     32'(ph == OC + 3 && m_gid == 1));
        chk("busy",     32'(busy),     32'(ph != 0));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
    endtask

    initial begin
        int last_ack;
        reset = 1'b1;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        @(negedge clk);
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lat_en", 32'(lat_en), 32'd0);

        // single write, data changed after grant must not leak through
        reset = 1'b0;
        req0 = 1; addr0 = 2; wdata0 = 8'hA5;
        step();
        wdata0 = 8'h00;
        chk("a5_setup_d",  32'(lat_d),  32'hA5);
        chk("a5_setup_en", 32'(lat_en), 32'd0);
        step(); chk("a5_open1", 32'(lat_en), 32'b100);
        step(); chk("a5_open2", 32'(lat_en), 32'b100);
        chk("a5_hold_d", 32'(lat_d), 32'hA5);
        step(); chk("a5_hold", 32'(lat_en), 32'd0);
        step(); chk("a5_ack", 32'(ack0), 32'd1);
        step(); chk("a5_idle", 32'(busy), 32'd0);

        // out-of-range address: no enable, normal ack
        req1 = 1; addr1 = 3; wdata1 = 8'h3C;
        for (int i = 0; i < OC + 4; i++) begin
            step();
            chk("oor_en", 32'(lat_en), 32'd0);
        end

        // both requesters held high: grants must alternate starting with 0
        last_ack = 1;
        for (int i = 0; i < 40; i++) begin
            req0 = 1; req1 = 1;
            addr0 = AW'(i); addr1 = AW'(i + 1);
            wdata0 = WIDTH'(i); wdata1 = WIDTH'(8'h80 + i);
            step();
            if (ack0 || ack1) begin
                chk("rr_alt", 32'(ack1), 32'(last_ack == 0));
                last_ack = ack1 ? 1 : 0;
            end
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < OC + 5; i++) step();

        // reset during the enable window
        req0 = 1; addr0 = 1; wdata0 = 8'h5A;
        step(); step();
        chk("pre_rst_en", 32'(lat_en), 32'b010);
        reset = 1; req0 = 0;
        step();
        chk("mid_rst_en",   32'(lat_en), 32'd0);
        chk("mid_rst_busy", 32'(busy),   32'd0);
        reset = 0;
        for (int i = 0; i < OC + 3; i++) begin
            step();
            chk("no_ack_after_rst", 32'(ack0), 32'd0);
        end
        req0 = 1; req1 = 1;
        step();
        chk("ptr_after_rst", 32'(grant_id), 32'd0);
        for (int i = 0; i < 2 * (OC + 4); i++) step();

        // random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(99) == 0);
            if (!req0 && $urandom_range(2) == 0) begin
                req0 = 1; addr0 = AW'($urandom); wdata0 = WIDTH'($urandom);
            end else if (req0 && $urandom_range(3) == 0) begin
                addr0 = AW'($urandom); wdata0 = WIDTH'($urandom);
            end
            if (!req1 && $urandom_range(2) == 0) begin
                req1 = 1; addr1 = AW'($urandom); wdata1 = WIDTH'($urandom);
            end else if (req1 && $urandom_range(3) == 0) begin
                addr1 = AW'($urandom); wdata1 = WIDTH'($urandom);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
